// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA fill blitter.
//   FB_WIDTH / FB_HEIGHT : framebuffer geometry in pixels
//   blit_cmd_t           : latched fill command {x0, y0, w, h, color}
//   blit_state_t         : blitter control states
//   fits / clip_len      : span helpers used by the bounds check in the CHECK state
package vga_pkg;

  localparam int unsigned FB_WIDTH  = 320;
  localparam int unsigned FB_HEIGHT = 240;

  typedef struct packed {
    logic [9:0]  x0;
    logic [9:0]  y0;
    logic [9:0]  w;
    logic [9:0]  h;
    logic [23:0] color;
  } blit_cmd_t;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StWrite,
    StDone
  } blit_state_t;

  // True when the span [org, org+len) lies entirely within [0, lim).
  function automatic logic fits(input logic [9:0] org, input logic [9:0] len,
                                input logic [10:0] lim);
    fits = ({1'b0, org} + {1'b0, len}) <= lim;
  endfunction

  // Length of the part of [org, org+len) that lies within [0, lim).
  function automatic logic [9:0] clip_len(input logic [9:0] org, input logic [9:0] len,
                                          input logic [10:0] lim);
    logic [10:0] end_pos;
    end_pos = {1'b0, org} + {1'b0, len};
    if ({1'b0, org} >= lim) begin
      clip_len = '0;
    end else if (end_pos > lim) begin
      clip_len = 10'(lim - {1'b0, org});
    end else begin
      clip_len = len;
    end
  endfunction

endpackage

// File: rtl/vga_blit_addr_gen.sv
// Row-major pixel address walker for the fill blitter.
//   clk, n_rst    : clock, asynchronous active-low reset
//   load_i        : capture start address and rectangle size, reset x/y to the origin
//   start_addr_i  : bus address of the rectangle's top-left pixel
//   w_i, h_i      : rectangle size in pixels (non-zero whenever beats are issued)
//   advance_i     : current beat completed, step to the next pixel
//   addr_o        : address of the pixel currently presented
//   last_o        : current pixel is the bottom-right corner of the rectangle
module vga_blit_addr_gen
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ADDR_SHIFT = 0
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [9:0]            w_i,
  input  logic [9:0]            h_i,
  input  logic                  advance_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);

  localparam logic [ADDR_WIDTH-1:0] PixStep = ADDR_WIDTH'(1) << ADDR_SHIFT;
  localparam logic [ADDR_WIDTH-1:0] RowStep = ADDR_WIDTH'(FB_WIDTH) << ADDR_SHIFT;

  logic [9:0]            x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d, addr_q, addr_d;
  logic                  row_end;

  assign row_end = (x_q == w_q - 10'd1);
  assign last_o  = row_end && (y_q == h_q - 10'd1);
  assign addr_o  = addr_q;

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    if (load_i) begin
      x_d        = '0;
      y_d        = '0;
      w_d        = w_i;
      h_d        = h_i;
      row_base_d = start_addr_i;
      addr_d     = start_addr_i;
    end else if (advance_i) begin
      if (row_end) begin
        // Next row restarts from the row base, not from the running address.
        x_d        = '0;
        y_d        = y_q + 10'd1;
        row_base_d = row_base_q + RowStep;
        addr_d     = row_base_q + RowStep;
      end else begin
        x_d    = x_q + 10'd1;
        addr_d = addr_q + PixStep;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
    end
  end

endmodule

// File: rtl/vga_fill_blitter.sv
// Bus initiator that fills a rectangle of the 320x240 framebuffer with one colour.
//   clk, n_rst                      : clock, asynchronous active-low reset
//   cmd_valid / cmd_ready           : command handshake (ready only while idle)
//   cmd_x0, cmd_y0, cmd_w, cmd_h    : rectangle origin and size in pixels
//   cmd_color                       : 24-bit {R,G,B} fill colour
//   busy, done, done_err            : progress; done pulses once, done_err qualifies it
//   bus_addr/wen/ren/wdata/strobe   : write-only bus initiator, one beat per pixel
//   bus_request_stall, bus_error    : target back-pressure and completing-beat error
// Build option VGA_BLIT_CLIP_EN: clip the rectangle to the framebuffer instead of
// rejecting a command that extends past its right or bottom edge.
module vga_fill_blitter
  import vga_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] FB_BASE   = '0,
  parameter int unsigned          ADDR_SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [9:0]              cmd_x0,
  input  logic [9:0]              cmd_y0,
  input  logic [9:0]              cmd_w,
  input  logic [9:0]              cmd_h,
  input  logic [23:0]             cmd_color,
  output logic                    busy,
  output logic                    done,
  output logic                    done_err,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic                    bus_wen,
  output logic                    bus_ren,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  output logic [DATA_WIDTH/8-1:0] bus_strobe,
  input  logic                    bus_request_stall,
  input  logic                    bus_error
);

  blit_state_t           state_q, state_d;
  blit_cmd_t             cmd_q, cmd_d;
  logic                  err_q, err_d;
  logic [9:0]            eff_w, eff_h;
  logic                  zero_size, reject, skip, beat, last;
  logic [ADDR_WIDTH-1:0] start_addr, gen_addr;

  assign zero_size = (cmd_q.w == '0) || (cmd_q.h == '0);

`ifdef VGA_BLIT_CLIP_EN
  assign eff_w  = clip_len(cmd_q.x0, cmd_q.w, 11'(FB_WIDTH));
  assign eff_h  = clip_len(cmd_q.y0, cmd_q.h, 11'(FB_HEIGHT));
  assign reject = 1'b0;
`else
  assign eff_w  = cmd_q.w;
  assign eff_h  = cmd_q.h;
  assign reject = !fits(cmd_q.x0, cmd_q.w, 11'(FB_WIDTH)) ||
                  !fits(cmd_q.y0, cmd_q.h, 11'(FB_HEIGHT));
`endif

  // A fully clipped rectangle shows up here as a zero effective size.
  assign skip = zero_size || (eff_w == '0) || (eff_h == '0) || reject;

  assign start_addr = FB_BASE + ((ADDR_WIDTH'(cmd_q.y0) * ADDR_WIDTH'(FB_WIDTH) +
                                  ADDR_WIDTH'(cmd_q.x0)) << ADDR_SHIFT);

  assign beat = (state_q == StWrite) && !bus_request_stall;

  vga_blit_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ADDR_SHIFT (ADDR_SHIFT)
  ) u_addr_gen (
    .clk          (clk),
    .n_rst        (n_rst),
    .load_i       (state_q == StCheck),
    .start_addr_i (start_addr),
    .w_i          (eff_w),
    .h_i          (eff_h),
    .advance_i    (beat),
    .addr_o       (gen_addr),
    .last_o       (last)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          cmd_d   = '{x0: cmd_x0, y0: cmd_y0, w: cmd_w, h: cmd_h, color: cmd_color};
          err_d   = 1'b0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (skip) begin
          // An empty rectangle is not an error even if its origin is off-screen.
          err_d   = reject && !zero_size;
          state_d = StDone;
        end else begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (beat) begin
          if (bus_error) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else if (last) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      cmd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode registered state only, so they never depend combinationally on inputs.
  assign cmd_ready  = (state_q == StIdle);
  assign busy       = (state_q == StCheck) || (state_q == StWrite);
  assign done       = (state_q == StDone);
  assign done_err   = done && err_q;
  assign bus_wen    = (state_q == StWrite);
  assign bus_ren    = 1'b0;
  assign bus_addr   = bus_wen ? gen_addr : '0;
  assign bus_wdata  = bus_wen ? DATA_WIDTH'({8'h00, cmd_q.color}) : '0;
  assign bus_strobe = {(DATA_WIDTH / 8){bus_wen}};

endmodule

// File: tb/tb_vga_fill_blitter.sv
// Self-checking bench for vga_fill_blitter: directed fills plus randomized commands,
// stalls and bus errors, each checked cycle by cycle against a pixel-list model.
module tb_vga_fill_blitter;

  localparam int unsigned MAXC = 400;
  localparam int          FBW  = 320;
  localparam int          FBH  = 240;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_x0 = '0, cmd_y0 = '0, cmd_w = '0, cmd_h = '0;
  logic [23:0] cmd_color = '0;
  logic        busy, done, done_err;
  logic [31:0] bus_addr;
  logic        bus_wen, bus_ren;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_strobe;
  logic        bus_request_stall = 1'b0;
  logic        bus_error = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  bit stall_a [MAXC];
  bit err_a   [MAXC];

  vga_fill_blitter u_dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_x0            (cmd_x0),
    .cmd_y0            (cmd_y0),
    .cmd_w             (cmd_w),
    .cmd_h             (cmd_h),
    .cmd_color         (cmd_color),
    .busy              (busy),
    .done              (done),
    .done_err          (done_err),
    .bus_addr          (bus_addr),
    .bus_wen           (bus_wen),
    .bus_ren           (bus_ren),
    .bus_wdata         (bus_wdata),
    .bus_strobe        (bus_strobe),
    .bus_request_stall (bus_request_stall),
    .bus_error         (bus_error)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command at cycle 0 and check every cycle through the return to idle.
  // stall_beat/stall_len: hold the stall for stall_len cycles when that beat is presented.
  // err_beat: raise bus_error on that completing beat (0 = none). rnd: random stalls.
  task automatic run_cmd(input int x0, input int y0, input int w, input int h,
                         input logic [23:0] col, input int stall_beat, input int stall_len,
                         input int err_beat, input bit rnd);
    int          ew, eh, k, done_t, beats, cnt;
    bit          exp_err, rej;
    logic [31:0] exp_addr [$];
    logic        exp_wen;

    // Reference region: the pixels the command should touch.
    ew = w;
    eh = h;
    rej = 1'b0;
`ifdef VGA_BLIT_CLIP_EN
    ew = (x0 >= FBW) ? 0 : ((x0 + w > FBW) ? FBW - x0 : w);
    eh = (y0 >= FBH) ? 0 : ((y0 + h > FBH) ? FBH - y0 : h);
`else
    rej = (w != 0) && (h != 0) && ((x0 + w > FBW) || (y0 + h > FBH));
`endif
    exp_err = rej;
    k = rej ? 0 : ew * eh;
    for (int r = 0; r < eh; r++)
      for (int c = 0; c < ew; c++)
        exp_addr.push_back(32'((y0 + r) * FBW + x0 + c));
    if (err_beat > 0 && err_beat <= k) begin
      k = err_beat;
      exp_err = 1'b1;
    end

    // Stall/error schedule, indexed by cycle relative to the accept cycle.
    for (int t = 0; t < MAXC; t++) begin
      if (rnd) stall_a[t] = (t >= 2) && ($urandom_range(3) == 0);
      else stall_a[t] = (stall_beat > 0) && (t >= 1 + stall_beat) &&
                        (t < 1 + stall_beat + stall_len);
      err_a[t] = 1'($urandom);
    end
    done_t = 2;
    if (k > 0) begin
      cnt = 0;
      done_t = MAXC - 2;
      for (int t = 2; t < MAXC - 2; t++) begin
        if (!stall_a[t]) begin
          cnt++;
          err_a[t] = (cnt == k) && (err_beat > 0) && (err_beat == k) && exp_err;
          if (cnt == k) begin
            done_t = t + 1;
            break;
          end
        end
      end
    end

    beats = 0;
    for (int t = 0; t <= done_t + 1; t++) begin
      @(negedge clk);
      exp_wen = (k > 0) && (t >= 2) && (t < done_t);
      chk("wen", 32'(bus_wen), 32'(exp_wen));
      chk("busy", 32'(busy), 32'((t >= 1) && (t < done_t)));
      chk("cmd_ready", 32'(cmd_ready), 32'((t == 0) || (t > done_t)));
      chk("done", 32'(done), 32'(t == done_t));
      chk("ren", 32'(bus_ren), 32'd0);
      if (t == done_t) chk("done_err", 32'(done_err), 32'(exp_err));
      if (exp_wen) begin
        chk("addr", bus_addr, exp_addr[beats]);
        chk("wdata", bus_wdata, {8'h00, col});
        chk("strobe", 32'(bus_strobe), 32'hf);
        if (!stall_a[t]) beats++;
      end else begin
        chk("strobe_idle", 32'(bus_strobe), 32'h0);
      end
      bus_request_stall = stall_a[t];
      bus_error = err_a[t];
      if (t == 0) begin
        cmd_valid = 1'b1;
        cmd_x0 = 10'(x0);
        cmd_y0 = 10'(y0);
        cmd_w = 10'(w);
        cmd_h = 10'(h);
        cmd_color = col;
      end else if (t <= done_t) begin
        // Commands offered while busy must be ignored.
        cmd_valid = 1'($urandom);
        cmd_x0 = 10'($urandom_range(50));
        cmd_y0 = 10'($urandom_range(50));
        cmd_w = 10'($urandom_range(1, 5));
        cmd_h = 10'($urandom_range(1, 5));
        cmd_color = 24'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
    end
    if (done_t >= MAXC - 2) chk("done_timeout", 32'(done_t), 32'(MAXC - 3));
  endtask

  initial begin
    int rx, ry, rw, rh, re;

    // Reset state
    #2 n_rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_err", 32'(done_err), 32'd0);
    chk("rst_wen", 32'(bus_wen), 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    n_rst = 1'b1;

    // Basic 3x2 fill, stall on beat 2, bus error on beat 4
    run_cmd(10, 20, 3, 2, 24'hFF8000, 0, 0, 0, 1'b0);
    run_cmd(10, 20, 3, 2, 24'hFF8000, 2, 3, 0, 1'b0);
    run_cmd(10, 20, 3, 2, 24'hFF8000, 0, 0, 4, 1'b0);
    // Right-edge overflow, zero width, exact-fit corners
    run_cmd(318, 0, 4, 1, 24'h123456, 0, 0, 0, 1'b0);
    run_cmd(5, 5, 0, 3, 24'h00FF00, 0, 0, 0, 1'b0);
    run_cmd(300, 230, 20, 10, 24'h0000FF, 0, 0, 0, 1'b0);
    run_cmd(0, 239, 1, 1, 24'hABCDEF, 0, 0, 0, 1'b0);
    run_cmd(100, 235, 2, 8, 24'h777777, 0, 0, 0, 1'b0);
    run_cmd(330, 10, 3, 3, 24'h010203, 0, 0, 0, 1'b0);

    // Reset in the middle of a fill
    @(negedge clk);
    bus_request_stall = 1'b0;
    bus_error = 1'b0;
    cmd_x0 = 10'd10;
    cmd_y0 = 10'd20;
    cmd_w = 10'd3;
    cmd_h = 10'd2;
    cmd_color = 24'hFF8000;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_wen", 32'(bus_wen), 32'd1);
    chk("mid_addr", bus_addr, 32'd6412);
    #3 n_rst = 1'b0;
    #1;
    chk("arst_wen", 32'(bus_wen), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_ready", 32'(cmd_ready), 32'd1);
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_wen", 32'(bus_wen), 32'd0);
    end

    // Randomized commands with random stalls and occasional bus errors
    for (int i = 0; i < 30; i++) begin
      rx = ($urandom_range(1) == 0) ? int'($urandom_range(330, 300)) : int'($urandom_range(60));
      ry = ($urandom_range(1) == 0) ? int'($urandom_range(250, 230)) : int'($urandom_range(60));
      rw = int'($urandom_range(12));
      rh = int'($urandom_range(6));
      re = ($urandom_range(3) == 0) ? int'($urandom_range(20, 1)) : 0;
      run_cmd(rx, ry, rw, rh, 24'($urandom), 0, 0, re, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
